elastic_demultiplexer: RTL and testbench

- Inverse of the elastic multiplexer: one elastic input stream is fanned out to a configurable subset of OUTPUT_NUM elastic outputs.
- Uses valid/stop handshake; a transfer occurs on a channel when valid=1 and stop=0 in the same cycle.
- A one-entry holding register captures each token. The block then forks it eagerly: each enabled output may accept independently, in any cycle.
- switch_context pulses once the token has been delivered to every enabled output, so the PE context sequencer can advance.

---
 rtl/elastic_demultiplexer_pkg.sv | 12 +
 rtl/elastic_demultiplexer_fork_branch.sv | 45 ++++
 rtl/elastic_demultiplexer.sv | 69 ++++++
 tb/tb_elastic_demultiplexer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_demultiplexer_pkg.sv
// Shared constants for the elastic demultiplexer and its fork branches.
// Latency: n/a (constants only).
// Backpressure: n/a.
package elastic_demultiplexer_pkg;

    localparam int DATA_WIDTH            = 32;
    localparam int INPUT_NUM             = 4;
    localparam int INPUT_NUM_BIT_LENGTH  = $clog2(INPUT_NUM);
    localparam int OUTPUT_NUM            = 4;
    localparam int OUTPUT_NUM_BIT_LENGTH = $clog2(OUTPUT_NUM);

endpackage

// File: rtl/elastic_demultiplexer_fork_branch.sv
// One branch of the eager fork: tracks whether this output has taken the held token.
// Latency: combinational valid/done from registered sent bit.
// Backpressure: keeps valid high until its consumer drops stop; never re-offers a taken token.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   full           holding register contains a token
//   mask_bit       this output is a destination of the held token
//   stop           consumer backpressure for this output
//   load           a new token is entering the holding register this cycle
//   all_done       every enabled output has the held token (this cycle)
//   valid          token offered to this output
//   done           this output needs nothing more for the held token
module elastic_fork_branch
    import elastic_demultiplexer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic full,
    input  logic mask_bit,
    input  logic stop,
    input  logic load,
    input  logic all_done,
    output logic valid,
    output logic done
);

    logic sent_reg;

    assign valid = full & mask_bit & ~sent_reg;
    // Done if already delivered, not a destination, or delivering right now.
    assign done  = sent_reg | ~mask_bit | ~stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent_reg <= 1'b0;
        end else if (load || all_done) begin
            // A new token (or retirement of the old one) restarts tracking.
            sent_reg <= 1'b0;
        end else if (full) begin
            sent_reg <= sent_reg | (valid & ~stop);
        end
    end

endmodule

// File: rtl/elastic_demultiplexer.sv
// Elastic 1-to-N demultiplexer: one-entry holding register forked eagerly to a masked set of outputs.
// Latency: token accepted in cycle N is offered in cycle N+1; 1 token/cycle when outputs never stall.
// Backpressure: stop_input high while a held token still awaits some enabled output; releases in the completing cycle.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   data_input/valid_input/stop_input      upstream elastic channel
//   data_output/valid_output/stop_output   per-output elastic channels (unpacked arrays)
//   output_enable_mask   destinations of the next token, captured at load
//   switch_context       one-cycle pulse when the held token reaches all its destinations
module elastic_demultiplexer
    import elastic_demultiplexer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  valid_input,
    output logic                  stop_input,
    output logic [DATA_WIDTH-1:0] data_output [OUTPUT_NUM],
    output logic                  valid_output [OUTPUT_NUM],
    input  logic                  stop_output [OUTPUT_NUM],
    input  logic [OUTPUT_NUM-1:0] output_enable_mask,
    output logic                  switch_context
);

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  full_reg;
    logic [OUTPUT_NUM-1:0] mask_reg;
    logic [OUTPUT_NUM-1:0] done;
    logic                  all_done;
    logic                  load;

    // full_reg gates everything so stop_output has no path to stop_input when empty.
    assign all_done       = full_reg & (&done);
    assign switch_context = all_done;
    assign stop_input     = full_reg & ~all_done;
    assign load           = valid_input & ~stop_input;

    for (genvar i = 0; i < OUTPUT_NUM; i++) begin : g_branch
        elastic_fork_branch u_branch (
            .clk      (clk),
            .reset    (reset),
            .full     (full_reg),
            .mask_bit (mask_reg[i]),
            .stop     (stop_output[i]),
            .load     (load),
            .all_done (all_done),
            .valid    (valid_output[i]),
            .done     (done[i])
        );
        assign data_output[i] = data_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
            mask_reg <= '0;
            full_reg <= 1'b0;
        end else if (load) begin
            // Loading in the completing cycle overwrites the retiring token.
            data_reg <= data_input;
            mask_reg <= output_enable_mask;
            full_reg <= 1'b1;
        end else if (all_done) begin
            full_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_elastic_demultiplexer.sv
module tb_elastic_demultiplexer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_input;
    logic        valid_input;
    logic        stop_input;
    logic [31:0] data_output [4];
    logic        valid_output [4];
    logic        stop_output [4];
    logic [3:0]  output_enable_mask;
    logic        switch_context;

    logic [3:0]  vv;
    int          checks   = 0;
    int          failures = 0;
    int          sc_count = 0;
    logic        capture  = 1'b0;
    logic [31:0] rx_q [$];

    elastic_demultiplexer dut (
        .clk                (clk),
        .reset              (reset),
        .data_input         (data_input),
        .valid_input        (valid_input),
        .stop_input         (stop_input),
        .data_output        (data_output),
        .valid_output       (valid_output),
        .stop_output        (stop_output),
        .output_enable_mask (output_enable_mask),
        .switch_context     (switch_context)
    );

    always #5 clk = ~clk;

    assign vv = {valid_output[3], valid_output[2], valid_output[1], valid_output[0]};

    // Inputs change just after posedge, so the negedge sees each cycle's settled handshake.
    always @(negedge clk) begin
        if (switch_context) sc_count++;
        if (capture && valid_output[3] && !stop_output[3]) rx_q.push_back(data_output[3]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int s0;
        int k;
        int cyc;
        logic acc;

        reset = 1'b1;
        data_input = '0;
        valid_input = 1'b0;
        output_enable_mask = '0;
        for (int i = 0; i < 4; i++) stop_output[i] = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", vv, 4'b0000);
        chk("rst_stop_input", stop_input, 1'b0);
        chk("rst_switch", switch_context, 1'b0);
        chk("rst_data", data_output[0], 32'h0);
        reset = 1'b0;
        tick();

        // Broadcast, back-to-back
        s0 = sc_count;
        valid_input = 1'b1; data_input = 32'hA5A5_0001; output_enable_mask = 4'b1111;
        settle();
        chk("bc_empty_stop_input", stop_input, 1'b0);
        tick();
        data_input = 32'hA5A5_0002;
        settle();
        chk("bc_valid1", vv, 4'b1111);
        chk("bc_switch1", switch_context, 1'b1);
        chk("bc_data1", data_output[2], 32'hA5A5_0001);
        chk("bc_stop_input_b2b", stop_input, 1'b0);
        tick();
        valid_input = 1'b0;
        settle();
        chk("bc_valid2", vv, 4'b1111);
        chk("bc_data2", data_output[3], 32'hA5A5_0002);
        chk("bc_switch2", switch_context, 1'b1);
        tick();
        chk("bc_idle_valid", vv, 4'b0000);
        chk("bc_idle_switch", switch_context, 1'b0);
        chk("bc_pulses", sc_count - s0, 2);

        // Staggered acceptance
        s0 = sc_count;
        valid_input = 1'b1; data_input = 32'h0000_0003; output_enable_mask = 4'b0101;
        stop_output[2] = 1'b1;
        tick();
        valid_input = 1'b0;
        settle();
        chk("st_c1_valid", vv, 4'b0101);
        chk("st_c1_stop_input", stop_input, 1'b1);
        chk("st_c1_switch", switch_context, 1'b0);
        tick();
        chk("st_c2_valid", vv, 4'b0100);
        chk("st_c2_stop_input", stop_input, 1'b1);
        tick();
        chk("st_c3_valid", vv, 4'b0100);
        chk("st_c3_switch", switch_context, 1'b0);
        stop_output[2] = 1'b0;
        settle();
        chk("st_c4_valid", vv, 4'b0100);
        chk("st_c4_stop_input", stop_input, 1'b0);
        chk("st_c4_switch", switch_context, 1'b1);
        tick();
        chk("st_after_valid", vv, 4'b0000);
        chk("st_pulses", sc_count - s0, 1);

        // Zero mask
        s0 = sc_count;
        valid_input = 1'b1; data_input = 32'h0000_0042; output_enable_mask = 4'b0000;
        settle();
        chk("zm_pre_stop_input", stop_input, 1'b0);
        tick();
        valid_input = 1'b0;
        settle();
        chk("zm_valid", vv, 4'b0000);
        chk("zm_switch", switch_context, 1'b1);
        chk("zm_stop_input", stop_input, 1'b0);
        tick();
        chk("zm_after_valid", vv, 4'b0000);
        chk("zm_after_switch", switch_context, 1'b0);
        chk("zm_pulses", sc_count - s0, 1);

        // Mask change while held
        valid_input = 1'b1; data_input = 32'h0000_0004; output_enable_mask = 4'b0010;
        stop_output[1] = 1'b1;
        tick();
        valid_input = 1'b0; output_enable_mask = 4'b1111;
        settle();
        chk("mc_c1_valid", vv, 4'b0010);
        tick();
        chk("mc_c2_valid", vv, 4'b0010);
        chk("mc_c2_stop_input", stop_input, 1'b1);
        stop_output[1] = 1'b0;
        settle();
        chk("mc_c3_valid", vv, 4'b0010);
        chk("mc_c3_switch", switch_context, 1'b1);
        tick();
        chk("mc_after_valid", vv, 4'b0000);

        // Reset mid-operation
        valid_input = 1'b1; data_input = 32'h0000_0005; output_enable_mask = 4'b0011;
        stop_output[1] = 1'b1;
        tick();
        valid_input = 1'b0;
        settle();
        chk("rm_c1_valid", vv, 4'b0011);
        tick();
        chk("rm_c2_valid", vv, 4'b0010);
        chk("rm_c2_stop_input", stop_input, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_async_valid", vv, 4'b0000);
        chk("rm_async_stop_input", stop_input, 1'b0);
        chk("rm_async_data", data_output[1], 32'h0);
        #2;
        reset = 1'b0;
        stop_output[1] = 1'b0;
        tick();
        chk("rm_after_valid", vv, 4'b0000);
        chk("rm_after_switch", switch_context, 1'b0);

        // Throughput with toggling stop on output 3
        s0 = sc_count;
        capture = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 200) begin
            valid_input = 1'b1;
            data_input = k;
            output_enable_mask = 4'b1000;
            stop_output[3] = cyc[0];
            settle();
            acc = !stop_input;
            tick();
            if (acc) k++;
            cyc++;
        end
        valid_input = 1'b0;
        for (int j = 0; j < 20 && rx_q.size() < 16; j++) begin
            stop_output[3] = cyc[0];
            cyc++;
            tick();
        end
        stop_output[3] = 1'b0;
        tick();
        tick();
        capture = 1'b0;
        chk("tp_sent", k, 16);
        chk("tp_rx_count", rx_q.size(), 16);
        for (int i = 0; i < rx_q.size(); i++) chk($sformatf("tp_rx_%0d", i), rx_q[i], i);
        chk("tp_pulses", sc_count - s0, 16);
        chk("tp_idle_valid", vv, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
